snn_config_sync: RTL and testbench
==================================

// Module: snn_config_sync
// PURPOSE
//  Consumes the SPI-domain ready flags and configuration bytes from the SPI register/memory
//  front end and moves them into the SNN core clock domain (clk).
//  Generates the divided SNN time-step tick from the written divider value.
//  Delivers input-spike bytes one per tick, and latches the debug configuration.
//  Sits between the SPI interface and the SNN core / debug mux.
// PARAMETERS
//  DIV_W        8  width of clock-divider value
//  SPIKE_W      8  width of input-spike word
//  DBG_W        8  width of debug configuration word
//  SYNC_STAGES  2  flip-flops per CDC synchronizer (>=2)
// PORTS
//  clk                    in   1        SNN core clock; single clock domain of this block
//  rst_n                  in   1        asynchronous, active-low reset
//  clk_div_ready_in       in   1        SPI-domain level flag: divider value valid (async)
//  input_spike_ready_in   in   1        SPI-domain level flag: new spike word written (async)
//  debug_config_ready_in  in   1        SPI-domain level flag: debug word written (async)
//  clk_div_cfg            in   DIV_W    divider byte from SPI memory; stable while its flag is high
//  spike_cfg              in   SPIKE_W  spike byte from SPI memory; stable for >=SYNC_STAGES+2 clk after flag rise
//  debug_cfg              in   DBG_W    debug byte from SPI memory; same stability rule
//  snn_tick               out  1        1-cycle pulse every (div+1) clk while running
//  running                out  1        high in RUN state
//  div_value              out  DIV_W    captured divider value
//  spike_data             out  SPIKE_W  last delivered spike word, held between deliveries
//  spike_valid            out  1        1-cycle pulse, coincident with snn_tick, when spike_data updated
//  spike_overrun          out  1        sticky: new spike captured while one still pending
//  debug_cfg_out          out  DBG_W    captured debug word, held
//  debug_valid            out  1        1-cycle pulse when debug_cfg_out updated
// BEHAVIOUR
//  - Reset: all outputs, counters, synchronizer flops and edge-detect flops = 0; state IDLE.
//  - Synchronizer per flag: sync[0]<=in ... sync[N-1]; prev<=sync[N-1]; rise = sync[N-1]&~prev,
//    fall = ~sync[N-1]&prev. Flag high at reset release counts as a rise.
//  - Latency: flag high before clk edge 1 -> rise seen after edge SYNC_STAGES -> capture at
//    edge SYNC_STAGES+1 (edge 3 for default).
//  - Divider FSM, states IDLE, RUN:
//    IDLE --clk_div rise--> RUN: div_value<=clk_div_cfg, cnt<=0.
//    RUN  --clk_div rise--> RUN: reload div_value, cnt<=0 (restart phase).
//    RUN  --clk_div fall--> IDLE: cnt<=0; no tick that cycle or after.
//    RUN: cnt<=(cnt==div_value)?0:cnt+1; snn_tick = RUN && cnt==div_value (from regs only).
//    div_value==0 -> snn_tick every cycle. cnt is DIV_W bits, never exceeds div_value.
//    First tick: div_value+1 cycles after RUN entry (cycle in which cnt first equals div_value).
//  - Spike path: on spike rise, spike_buf<=spike_cfg, pending<=1.
//    On snn_tick with pending: spike_data<=spike_buf, spike_valid=1 (registered with tick
//    cycle, i.e. asserted during the tick cycle via pending&snn_tick), pending cleared.
//    Rise and delivering tick in same cycle: old spike_buf delivered, new value loaded,
//    pending stays 1, no overrun. Rise while pending and no tick: overwrite spike_buf,
//    spike_overrun<=1 (cleared only by rst_n). Pending holds indefinitely in IDLE.
//  - Debug path: on debug rise, debug_cfg_out<=debug_cfg; debug_valid high next cycle only.
//  - Falls of spike/debug flags: no action. rst_n low mid-operation: immediate return to reset
//    values; pending data discarded.
// STRUCTURE
//  - Shared package snn_cfg_pkg: FSM state encoding (IDLE=1'b0, RUN=1'b1), default
//    SYNC_STAGES, DIV_W/SPIKE_W/DBG_W defaults.
//  - Sub-module cdc_sync_edge (#SYNC_STAGES): in -> level, rise, fall; instantiated 3 times.
//  - Top: divider FSM + counter, spike buffer/pending/overrun, debug latch.
// TESTING
//  1 Reset all flags low, release rst_n -> all outputs 0 for 20 cycles, running=0.
//  2 clk_div_cfg=3, raise clk_div_ready -> running at edge 3, snn_tick every 4th cycle,
//    first tick 4 cycles after running.
//  3 clk_div_cfg=0 while running, toggle flag low/high -> IDLE (no ticks), then tick every cycle.
//  4 Running div=3, spike_cfg=8'hA5 flag rise -> spike_valid with next snn_tick, spike_data=A5,
//    held until next delivery; no repeat pulse on later ticks.
//  5 Two spike rises (11, 22) within one tick period -> delivers 22, spike_overrun=1 sticky;
//    rise aligned exactly on tick cycle -> old word delivered, new pending, overrun stays 0.
//  6 debug_cfg=8'h5C flag rise -> debug_cfg_out=5C, debug_valid one cycle; rst_n pulse
//    mid-RUN -> all outputs 0 immediately, ticks stop until next clk_div rise.

Source files
------------

// File: rtl/snn_cfg_pkg.sv
// Shared types and defaults for the SNN configuration synchronizer.
package snn_cfg_pkg;

  // Divider FSM encoding
  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } div_state_e;

  localparam int unsigned DefDivW       = 8;
  localparam int unsigned DefSpikeW     = 8;
  localparam int unsigned DefDbgW       = 8;
  localparam int unsigned DefSyncStages = 2;

endpackage : snn_cfg_pkg

// File: rtl/cdc_sync_edge.sv
// Multi-flop level synchronizer with rise/fall detection on the synchronized level.
module cdc_sync_edge
  import snn_cfg_pkg::*;
#(
  parameter int unsigned SyncStages = DefSyncStages
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SyncStages-1:0] sync_d, sync_q;
  logic                  prev_d, prev_q;

  // Shift the async level through the chain; prev tracks the last synchronized value
  always_comb begin
    sync_d = {sync_q[SyncStages-2:0], in_i};
    prev_d = sync_q[SyncStages-1];
  end

  // Synchronizer and edge-detect flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // prev resets low, so a flag already high at reset release shows up as a rise
  always_comb begin
    level_o = sync_q[SyncStages-1];
    rise_o  = sync_q[SyncStages-1] & ~prev_q;
    fall_o  = ~sync_q[SyncStages-1] & prev_q;
  end

endmodule : cdc_sync_edge

// File: rtl/snn_config_sync.sv
// Moves SPI-side configuration into the SNN core domain: time-step divider,
// one-per-tick spike word delivery and debug word latch.
module snn_config_sync
  import snn_cfg_pkg::*;
#(
  parameter int unsigned DIV_W       = DefDivW,
  parameter int unsigned SPIKE_W     = DefSpikeW,
  parameter int unsigned DBG_W       = DefDbgW,
  parameter int unsigned SYNC_STAGES = DefSyncStages
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_div_ready_in,
  input  logic               input_spike_ready_in,
  input  logic               debug_config_ready_in,
  input  logic [DIV_W-1:0]   clk_div_cfg,
  input  logic [SPIKE_W-1:0] spike_cfg,
  input  logic [DBG_W-1:0]   debug_cfg,
  output logic               snn_tick,
  output logic               running,
  output logic [DIV_W-1:0]   div_value,
  output logic [SPIKE_W-1:0] spike_data,
  output logic               spike_valid,
  output logic               spike_overrun,
  output logic [DBG_W-1:0]   debug_cfg_out,
  output logic               debug_valid
);

  logic div_rise, div_fall, unused_div_level;
  logic spike_rise, unused_spike_level, unused_spike_fall;
  logic dbg_rise, unused_dbg_level, unused_dbg_fall;

  cdc_sync_edge #(
    .SyncStages(SYNC_STAGES)
  ) u_sync_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_i   (clk_div_ready_in),
    .level_o(unused_div_level),
    .rise_o (div_rise),
    .fall_o (div_fall)
  );

  cdc_sync_edge #(
    .SyncStages(SYNC_STAGES)
  ) u_sync_spike (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_i   (input_spike_ready_in),
    .level_o(unused_spike_level),
    .rise_o (spike_rise),
    .fall_o (unused_spike_fall)
  );

  cdc_sync_edge #(
    .SyncStages(SYNC_STAGES)
  ) u_sync_dbg (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_i   (debug_config_ready_in),
    .level_o(unused_dbg_level),
    .rise_o (dbg_rise),
    .fall_o (unused_dbg_fall)
  );

  div_state_e           state_d, state_q;
  logic [DIV_W-1:0]     cnt_d, cnt_q;
  logic [DIV_W-1:0]     div_value_d, div_value_q;
  logic [SPIKE_W-1:0]   spike_buf_d, spike_buf_q;
  logic [SPIKE_W-1:0]   spike_data_d, spike_data_q;
  logic                 pending_d, pending_q;
  logic                 overrun_d, overrun_q;
  logic [DBG_W-1:0]     debug_d, debug_q;
  logic                 debug_valid_d, debug_valid_q;
  logic                 tick;
  logic                 deliver;

  // Tick from registered state; a fall in progress suppresses the tick of that cycle
  always_comb begin
    tick    = (state_q == StRun) && (cnt_q == div_value_q) && !div_fall;
    deliver = pending_q & tick;
  end

  // Divider FSM and phase counter; any rise restarts the phase with the new value
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_value_d = div_value_q;
    unique case (state_q)
      StIdle: begin
        if (div_rise) begin
          state_d     = StRun;
          div_value_d = clk_div_cfg;
          cnt_d       = '0;
        end
      end
      StRun: begin
        if (div_rise) begin
          div_value_d = clk_div_cfg;
          cnt_d       = '0;
        end else if (div_fall) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = (cnt_q == div_value_q) ? '0 : cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Spike buffer: deliver on tick, refill on rise; overrun only if the buffer is not drained
  always_comb begin
    spike_buf_d  = spike_buf_q;
    spike_data_d = spike_data_q;
    pending_d    = pending_q;
    overrun_d    = overrun_q;
    if (deliver) begin
      spike_data_d = spike_buf_q;
      pending_d    = 1'b0;
    end
    if (spike_rise) begin
      spike_buf_d = spike_cfg;
      pending_d   = 1'b1;
      if (pending_q && !deliver) begin
        overrun_d = 1'b1;
      end
    end
  end

  // Debug latch with a one-cycle valid aligned to the updated value
  always_comb begin
    debug_d       = dbg_rise ? debug_cfg : debug_q;
    debug_valid_d = dbg_rise;
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      div_value_q   <= '0;
      spike_buf_q   <= '0;
      spike_data_q  <= '0;
      pending_q     <= 1'b0;
      overrun_q     <= 1'b0;
      debug_q       <= '0;
      debug_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      div_value_q   <= div_value_d;
      spike_buf_q   <= spike_buf_d;
      spike_data_q  <= spike_data_d;
      pending_q     <= pending_d;
      overrun_q     <= overrun_d;
      debug_q       <= debug_d;
      debug_valid_q <= debug_valid_d;
    end
  end

  // Output mapping
  always_comb begin
    snn_tick      = tick;
    running       = (state_q == StRun);
    div_value     = div_value_q;
    spike_data    = spike_data_q;
    spike_valid   = deliver;
    spike_overrun = overrun_q;
    debug_cfg_out = debug_q;
    debug_valid   = debug_valid_q;
  end

endmodule : snn_config_sync

// File: tb/tb_snn_config_sync.sv
// Directed bench for snn_config_sync with a spike-word scoreboard.
module tb_snn_config_sync;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_div_ready_in = 1'b0;
  logic       input_spike_ready_in = 1'b0;
  logic       debug_config_ready_in = 1'b0;
  logic [7:0] clk_div_cfg = '0;
  logic [7:0] spike_cfg = '0;
  logic [7:0] debug_cfg = '0;
  logic       snn_tick, running, spike_valid, spike_overrun, debug_valid;
  logic [7:0] div_value, spike_data, debug_cfg_out;

  snn_config_sync dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .clk_div_ready_in     (clk_div_ready_in),
    .input_spike_ready_in (input_spike_ready_in),
    .debug_config_ready_in(debug_config_ready_in),
    .clk_div_cfg          (clk_div_cfg),
    .spike_cfg            (spike_cfg),
    .debug_cfg            (debug_cfg),
    .snn_tick             (snn_tick),
    .running              (running),
    .div_value            (div_value),
    .spike_data           (spike_data),
    .spike_valid          (spike_valid),
    .spike_overrun        (spike_overrun),
    .debug_cfg_out        (debug_cfg_out),
    .debug_valid          (debug_valid)
  );

  always #5 clk = ~clk;

  int unsigned chk_cnt = 0;
  int unsigned pass_cnt = 0;
  int unsigned pulses = 0;
  logic [7:0]  sb_q[$];
  logic [7:0]  exp_spike;
  logic        chk_next = 1'b0;
  logic [28:0] all_out;

  assign all_out = {snn_tick, running, div_value, spike_data, spike_valid, spike_overrun,
                    debug_cfg_out, debug_valid};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cycn(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Scoreboard: each spike_valid pops the expected word, checked once spike_data updates
  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      if (chk_next) begin
        check("spike_data", {24'd0, spike_data}, {24'd0, exp_spike});
        chk_next = 1'b0;
      end
      if (spike_valid) begin
        pulses++;
        check("valid_on_tick", {31'd0, snn_tick}, 32'd1);
        check("sb_nonempty", {31'd0, sb_q.size() != 0}, 32'd1);
        if (sb_q.size() != 0) begin
          exp_spike = sb_q.pop_front();
          chk_next  = 1'b1;
        end
      end
    end
  end

  initial begin
    logic found;

    // 1: reset, all flags low
    cycn(2);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      check("idle_outputs", {3'd0, all_out}, 32'd0);
    end

    // 2: divider 3 -> running at edge 3, tick every 4th cycle
    clk_div_cfg = 8'd3;
    clk_div_ready_in = 1'b1;
    cyc();
    check("run_e1", {31'd0, running}, 32'd0);
    cyc();
    check("run_e2", {31'd0, running}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      cyc();
      check("run_on", {31'd0, running}, 32'd1);
      check("tick_div3", {31'd0, snn_tick}, {31'd0, (i % 4) == 3});
    end
    check("div_value3", {24'd0, div_value}, 32'd3);

    // 3: drop flag -> idle, then divider 0 -> tick every cycle
    clk_div_ready_in = 1'b0;
    clk_div_cfg = 8'd0;
    cycn(3);
    for (int i = 0; i < 6; i++) begin
      check("idle_after_fall", {30'd0, running, snn_tick}, 32'd0);
      cyc();
    end
    clk_div_ready_in = 1'b1;
    cycn(3);
    for (int i = 0; i < 6; i++) begin
      check("tick_div0", {30'd0, running, snn_tick}, 32'd3);
      cyc();
    end

    // 4: divider 3, single spike A5 delivered once
    clk_div_ready_in = 1'b0;
    cycn(4);
    clk_div_cfg = 8'd3;
    clk_div_ready_in = 1'b1;
    cycn(3);
    spike_cfg = 8'hA5;
    input_spike_ready_in = 1'b1;
    sb_q.push_back(8'hA5);
    cycn(6);
    input_spike_ready_in = 1'b0;
    cycn(12);
    check("a5_pulses", pulses, 32'd1);
    check("a5_held", {24'd0, spike_data}, 32'hA5);

    // 5b: rise lands on a delivering tick -> old word out, new word pending, no overrun
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc();
      if (snn_tick) found = 1'b1;
    end
    check("tick_seen", {31'd0, found}, 32'd1);
    cycn(3);
    spike_cfg = 8'h33;
    input_spike_ready_in = 1'b1;
    sb_q.push_back(8'h33);
    cyc();
    input_spike_ready_in = 1'b0;
    cycn(2);
    spike_cfg = 8'h44;
    input_spike_ready_in = 1'b1;
    sb_q.push_back(8'h44);
    cycn(12);
    input_spike_ready_in = 1'b0;
    check("aligned_pulses", pulses, 32'd3);
    check("aligned_no_overrun", {31'd0, spike_overrun}, 32'd0);
    check("aligned_sb_empty", sb_q.size(), 32'd0);
    check("aligned_last", {24'd0, spike_data}, 32'h44);

    // 5a: two writes while idle -> newer word kept, overrun sticky
    clk_div_ready_in = 1'b0;
    cycn(4);
    spike_cfg = 8'h11;
    input_spike_ready_in = 1'b1;
    cycn(5);
    input_spike_ready_in = 1'b0;
    cycn(3);
    spike_cfg = 8'h22;
    input_spike_ready_in = 1'b1;
    sb_q.push_back(8'h22);
    cycn(5);
    check("overrun_set", {31'd0, spike_overrun}, 32'd1);
    check("held_in_idle", pulses, 32'd3);
    check("idle_not_running", {31'd0, running}, 32'd0);
    input_spike_ready_in = 1'b0;
    clk_div_cfg = 8'd3;
    clk_div_ready_in = 1'b1;
    cycn(12);
    check("overrun_pulses", pulses, 32'd4);
    check("overrun_sb_empty", sb_q.size(), 32'd0);
    check("overrun_word", {24'd0, spike_data}, 32'h22);
    check("overrun_sticky", {31'd0, spike_overrun}, 32'd1);

    // 6: debug latch, then asynchronous reset mid-run
    debug_cfg = 8'h5C;
    debug_config_ready_in = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      check("debug_valid", {31'd0, debug_valid}, {31'd0, i == 3});
      check("debug_out", {24'd0, debug_cfg_out}, (i >= 3) ? 32'h5C : 32'h0);
    end
    debug_config_ready_in = 1'b0;
    cycn(4);
    check("pre_reset_running", {31'd0, running}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {3'd0, all_out}, 32'd0);
    cycn(2);
    check("reset_held_outputs", {3'd0, all_out}, 32'd0);
    rst_n = 1'b1;
    cyc();
    check("post_reset_e1", {30'd0, running, snn_tick}, 32'd0);
    cyc();
    check("post_reset_e2", {30'd0, running, snn_tick}, 32'd0);
    cyc();
    check("post_reset_run", {31'd0, running}, 32'd1);
    check("post_reset_overrun", {31'd0, spike_overrun}, 32'd0);
    cycn(2);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule : tb_snn_config_sync
